// File: rtl/head_sram_rd_streamer.sv
// Head SRAM read streamer: issues len row reads from base_addr (row field wraps inside the bank)
// and streams the returned rows through a credit-protected output FIFO with valid/ready handshake.
`ifndef MAC_MULT_NUM
`define MAC_MULT_NUM 8
`endif
`ifndef IDATA_WIDTH
`define IDATA_WIDTH 8
`endif
`ifndef HEAD_SRAM_DEPTH
`define HEAD_SRAM_DEPTH 16
`endif

module head_sram_rd_streamer #(
    parameter int DATA_WIDTH = `MAC_MULT_NUM*`IDATA_WIDTH,
    parameter int BANK_DEPTH = `HEAD_SRAM_DEPTH,
    parameter int ADDR_WIDTH = $clog2(`MAC_MULT_NUM)+$clog2(BANK_DEPTH),
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4,
    localparam int LEN_W     = $clog2(BANK_DEPTH)+1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    output logic                  done,
    output logic                  sram_ren,
    output logic [ADDR_WIDTH-1:0] sram_raddr,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int ROW_W  = $clog2(BANK_DEPTH);
    localparam int BANK_W = ADDR_WIDTH - ROW_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH+RD_LAT+1) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [BANK_W-1:0]      bank_q;
    logic [ROW_W-1:0]       row_q;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       iss_cnt;
    logic [LEN_W-1:0]       out_cnt;
    logic                   done_q;
    logic [RD_LAT-1:0]      vld_pipe;
    logic [PTR_W:0]         wr_ptr, rd_ptr;
    logic [PTR_W:0]         fifo_cnt;
    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];

    logic                   take_cmd;
    logic                   ren;
    logic                   credit;
    logic                   fifo_wr;
    logic                   pop;
    logic                   issue_last;
    logic [CNT_W-1:0]       inflight;

    assign fifo_cnt   = wr_ptr - rd_ptr;
    assign fifo_wr    = vld_pipe[RD_LAT-1];
    assign out_vld    = (fifo_cnt != '0);
    assign pop        = out_vld && out_rdy;
    assign out_last   = out_vld && (out_cnt == len_q - LEN_W'(1));
    assign out_data   = out_vld ? mem[rd_ptr[PTR_W-1:0]] : '0;
    assign issue_last = (iss_cnt + LEN_W'(1) == len_q);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign sram_ren   = ren;
    assign sram_raddr = ren ? {bank_q, row_q} : '0;

    // Reads already in the pipe still need a FIFO slot, so they count against the credit.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_pipe[i]);
        end
    end

    assign credit = (inflight + CNT_W'(fifo_cnt)) < CNT_W'(FIFO_DEPTH);

    always_comb begin
        state_d  = state_q;
        ren      = 1'b0;
        take_cmd = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    take_cmd = 1'b1;
                    if (len != '0) state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (credit) begin
                    ren = 1'b1;
                    if (issue_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && out_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_q  <= '0;
            row_q   <= '0;
            len_q   <= '0;
            iss_cnt <= '0;
        end else if (take_cmd) begin
            bank_q  <= base_addr[ADDR_WIDTH-1 -: BANK_W];
            row_q   <= base_addr[ROW_W-1:0];
            len_q   <= len;
            iss_cnt <= '0;
        end else if (ren) begin
            // Row field wraps on its own width; the bank field is never carried into.
            row_q   <= row_q + ROW_W'(1);
            iss_cnt <= iss_cnt + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)         out_cnt <= '0;
        else if (take_cmd) out_cnt <= '0;
        else if (pop)      out_cnt <= out_cnt + LEN_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) done_q <= 1'b0;
        else       done_q <= (state_q == IDLE && start && len == '0) ||
                             (state_q == DRAIN && pop && out_last);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= ren;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Storage needs no reset: visibility is governed by the pointers alone.
    always_ff @(posedge clk) begin
        if (fifo_wr) mem[wr_ptr[PTR_W-1:0]] <= sram_rdata;
    end

endmodule

// File: tb/tb_head_sram_rd_streamer.sv
// Directed bench for head_sram_rd_streamer: 1-cycle SRAM model, negedge monitor, hand-computed expectations.
module tb_head_sram_rd_streamer;

    localparam int DW = 64;
    localparam int AW = 7;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] len = '0;
    logic          busy, done, sram_ren, out_vld, out_last;
    logic [AW-1:0] sram_raddr;
    logic [DW-1:0] sram_rdata = '0;
    logic          out_rdy = 1'b0;
    logic [DW-1:0] out_data;

    head_sram_rd_streamer #(
        .DATA_WIDTH(DW), .BANK_DEPTH(16), .ADDR_WIDTH(AW), .RD_LAT(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .sram_ren(sram_ren), .sram_raddr(sram_raddr),
        .sram_rdata(sram_rdata), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return {32'h5A5A_C3C3, 25'd0, a};
    endfunction

    always @(posedge clk) sram_rdata <= sram_ren ? pat(sram_raddr) : 64'hDEAD_BEEF_DEAD_BEEF;

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    logic [AW-1:0] rd_q[$];
    logic [DW-1:0] beat_d[$];
    logic          beat_l[$];
    int done_cnt, busy_seen, vld_seen, done_cyc, last_beat_cyc, start_cyc;
    int raddr_bad = 0, last_bad = 0, stall_bad = 0, done_busy = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (sram_ren) rd_q.push_back(sram_raddr);
        if (!sram_ren && sram_raddr != '0) raddr_bad++;
        if (out_last && !out_vld) last_bad++;
        if (busy) busy_seen++;
        if (out_vld) vld_seen++;
        if (rstn && prev_stall && out_data !== prev_data) stall_bad++;
        prev_stall = out_vld && !out_rdy;
        prev_data  = out_data;
        if (out_vld && out_rdy) begin
            beat_d.push_back(out_data);
            beat_l.push_back(out_last);
            if (out_last) last_beat_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy) done_busy++;
        end
        if (start && !busy) start_cyc = cyc;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic clear_mon();
        rd_q.delete();
        beat_d.delete();
        beat_l.delete();
        done_cnt = 0; busy_seen = 0; vld_seen = 0;
        done_cyc = -1; last_beat_cyc = -100; start_cyc = -100;
    endtask

    task automatic send(input logic [AW-1:0] b, input logic [LW-1:0] l);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_cnt >= target) break;
        end
        chk(tag, 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic chk_stream(input string tag, input logic [AW-1:0] exp_a[$], input int last_mask);
        logic [15:0] lv;
        chk({tag, "_nrd"}, 64'(rd_q.size()), 64'(exp_a.size()));
        chk({tag, "_nbeat"}, 64'(beat_d.size()), 64'(exp_a.size()));
        lv = '0;
        for (int k = 0; k < exp_a.size(); k++) begin
            chk({tag, "_addr"}, 64'(rd_q.size() > k ? rd_q[k] : 'x), 64'(exp_a[k]));
            chk({tag, "_data"}, beat_d.size() > k ? beat_d[k] : 'x, pat(exp_a[k]));
            lv = {lv[14:0], (beat_l.size() > k) ? beat_l[k] : 1'b0};
        end
        chk({tag, "_last"}, 64'(lv), 64'(last_mask));
    endtask

    initial begin
        logic [AW-1:0] ea[$];
        clear_mon();
        #3;
        chk("rst_outputs", 64'({busy, done, sram_ren, sram_raddr, out_vld, out_last}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // S1: rows 5,6,7 with consumer always ready
        clear_mon(); out_rdy = 1'b1;
        send(7'h05, 5'd3);
        wait_done(1, 40, "s1_done");
        ea = '{7'h05, 7'h06, 7'h07};
        chk_stream("s1", ea, 'b001);
        chk("s1_done_lat", 64'(done_cyc), 64'(last_beat_cyc + 1));

        // S2: back-pressure; credit limits issue to 4 reads
        clear_mon(); out_rdy = 1'b0;
        send(7'h10, 5'd6);
        repeat (10) @(posedge clk);
        #1;
        chk("s2_nrd_stall", 64'(rd_q.size()), 64'd4);
        chk("s2_ren_stall", 64'(sram_ren), 64'd0);
        chk("s2_vld_hold", 64'(out_vld), 64'd1);
        chk("s2_data_hold", out_data, pat(7'h10));
        out_rdy = 1'b1;
        wait_done(1, 60, "s2_done");
        ea = '{7'h10, 7'h11, 7'h12, 7'h13, 7'h14, 7'h15};
        chk_stream("s2", ea, 'b000001);

        // S3: bank 3, row 14 -> row wraps, bank held
        clear_mon();
        send({3'd3, 4'd14}, 5'd4);
        wait_done(1, 40, "s3_done");
        ea = '{7'h3E, 7'h3F, 7'h30, 7'h31};
        chk_stream("s3", ea, 'b0001);

        // S4: len=0 -> immediate done, no reads, never busy
        clear_mon();
        send(7'h07, 5'd0);
        chk("s4_done_now", 64'(done), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("s4_done_cnt", 64'(done_cnt), 64'd1);
        chk("s4_nrd", 64'(rd_q.size()), 64'd0);
        chk("s4_busy_seen", 64'(busy_seen), 64'd0);
        chk("s4_done_lat", 64'(done_cyc), 64'(start_cyc + 1));

        // S5: start while busy ignored; start in done cycle accepted
        clear_mon();
        send(7'h20, 5'd3);
        chk("s5_busy", 64'(busy), 64'd1);
        send(7'h40, 5'd2);
        for (int i = 0; i < 50; i++) begin
            if (done) break;
            @(posedge clk); #1;
        end
        chk("s5_done_seen", 64'(done), 64'd1);
        start = 1'b1; base_addr = 7'h50; len = 5'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2, 40, "s5_done2");
        ea = '{7'h20, 7'h21, 7'h22, 7'h50, 7'h51};
        chk_stream("s5", ea, 'b00101);

        // S6: reset after two beats aborts the command
        clear_mon();
        send(7'h00, 5'd5);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (beat_d.size() >= 2) break;
        end
        chk("s6_two_beats", 64'(beat_d.size() >= 2), 64'd1);
        rstn = 1'b0;
        #1;
        chk("s6_rst_outputs", 64'({busy, done, sram_ren, sram_raddr, out_vld, out_last}), 64'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        clear_mon();
        repeat (12) @(posedge clk);
        #1;
        chk("s6_no_vld", 64'(vld_seen), 64'd0);
        chk("s6_no_done", 64'(done_cnt), 64'd0);
        chk("s6_no_busy", 64'(busy_seen), 64'd0);

        chk("raddr_idle_zero", 64'(raddr_bad), 64'd0);
        chk("last_qualified", 64'(last_bad), 64'd0);
        chk("stall_stable", 64'(stall_bad), 64'd0);
        chk("done_not_busy", 64'(done_busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/head_sram_rd_streamer.md
HEAD_SRAM_RD_STREAMER -- requirements
Module: head_sram_rd_streamer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default `MAC_MULT_NUM*`IDATA_WIDTH, meaning the SRAM row width and the output word width.
REQ-002 The block SHALL have parameter BANK_DEPTH, default `HEAD_SRAM_DEPTH, meaning the number of SRAM rows.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default $clog2(`MAC_MULT_NUM)+$clog2(BANK_DEPTH), meaning the SRAM read-address width: bank-select field in the MSBs, row field in the LSBs.
REQ-004 The block SHALL have parameter RD_LAT, default 1, meaning the cycles from sram_ren to valid sram_rdata.
REQ-005 The block SHALL have parameter FIFO_DEPTH, default 4 (power of 2, >= RD_LAT+1), meaning the output buffer entries.
REQ-006 The block SHALL have ports:
  clk  in  1  clock; single clock domain.
  rstn  in  1  asynchronous active-low reset.
  start  in  1  one-cycle command pulse.
  base_addr  in  ADDR_WIDTH  first read address.
  len  in  $clog2(BANK_DEPTH)+1  number of rows to stream.
  busy  out  1  a command is in progress.
  done  out  1  one-cycle completion pulse.
  sram_ren  out  1  SRAM read enable.
  sram_raddr  out  ADDR_WIDTH  SRAM read address.
  sram_rdata  in  DATA_WIDTH  SRAM read data.
  out_vld  out  1  out_data is valid.
  out_rdy  in  1  consumer accepts.
  out_data  out  DATA_WIDTH  streamed row.
  out_last  out  1  marks the final row of a command.

Function
REQ-007 The state machine SHALL have three states, IDLE, ISSUE and DRAIN; busy SHALL be 1 in ISSUE and DRAIN.
REQ-008 In IDLE, start SHALL latch base_addr and len; the next state SHALL be ISSUE when len>0, else IDLE with done=1 in the following cycle and no SRAM reads.
REQ-009 start SHALL be ignored while busy=1.
REQ-010 In ISSUE, sram_ren SHALL assert only when (reads in flight + FIFO occupancy) < FIFO_DEPTH.
REQ-011 Each issued read SHALL drive sram_raddr combinationally with sram_ren in the same cycle; sram_raddr SHALL be 0 when sram_ren=0.
REQ-012 The k-th read (k=0..len-1) SHALL use bank field = base_addr bank field and row field = (base_addr row field + k) mod BANK_DEPTH, so the row wraps and the bank is never carried into.
REQ-013 After the len-th read is issued, the state SHALL move to DRAIN.
REQ-014 sram_rdata SHALL be captured into the FIFO exactly RD_LAT cycles after each sram_ren, tracked by an RD_LAT-deep valid shift register.
REQ-015 The credit rule in REQ-010 SHALL guarantee that the FIFO never overflows and no read data is dropped.
REQ-016 out_vld SHALL equal FIFO not-empty; out_data SHALL be the FIFO head; a transfer SHALL occur when out_vld&&out_rdy.
REQ-017 out_data SHALL be held stable while out_vld=1 and out_rdy=0.
REQ-018 Rows SHALL be output in issue order.
REQ-019 out_last SHALL be 1 only on the len-th row of the command, qualified by out_vld.
REQ-020 A FIFO write and read in the same cycle SHALL leave the occupancy unchanged; a write into an empty FIFO SHALL appear on out_vld the next cycle.
REQ-021 In DRAIN, the transfer of the out_last row SHALL set done=1 on the next cycle, return the state to IDLE and clear busy in that same cycle.
REQ-022 A start in the cycle done=1 SHALL be accepted.
REQ-023 The row count SHALL be $clog2(BANK_DEPTH)+1 bits; len=BANK_DEPTH SHALL read every row exactly once.

Reset
REQ-024 While rstn=0, the block SHALL be in IDLE with busy=0, done=0, sram_ren=0, sram_raddr=0, out_vld=0 and out_last=0, with the FIFO, in-flight tracker and counters cleared.
REQ-025 Asserting reset mid-command SHALL abort the command; in-flight data SHALL be discarded and no done SHALL be produced.

Verification
REQ-026 Scenario 1: base_addr=0x005, len=3, out_rdy=1 -> reads from rows 5, 6, 7; three out_vld beats with last on the third; done one cycle after the third beat.
REQ-027 Scenario 2: len=6, out_rdy=0 -> exactly FIFO_DEPTH reads issued, then sram_ren stalls; releasing out_rdy=1 delivers all 6 rows in order with no loss or duplicates.
REQ-028 Scenario 3: base_addr row field=BANK_DEPTH-2, bank field=3, len=4 -> rows BANK_DEPTH-2, BANK_DEPTH-1, 0, 1, with bank field 3 on every read.
REQ-029 Scenario 4: start with len=0 -> no sram_ren; done=1 one cycle later; busy stays 0.
REQ-030 Scenario 5: a second start while busy is ignored; a back-to-back start in the done cycle runs a full second command.
REQ-031 Scenario 6: rstn pulled low after 2 of 5 rows -> all outputs 0 immediately; after reset release, out_vld=0 and no done is produced.
